dot_product: RTL and testbench
==============================

Name: dot_product

Overview:
- Memory-mapped Q16.16 dot-product accelerator for the DNN datapath.
- A CPU programs it through an Avalon-MM slave port: weight vector address, input vector address and length, then start.
- It fetches both vectors word by word through an Avalon-MM master port and accumulates the sum of products.
- The CPU reads the result from slave word 0; that read stalls until the computation finishes.

Parameters:
- None. All data and addresses are 32 bits; the slave address is a 4-bit word offset.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- slave_waitrequest  out  1  stalls a slave access while a computation is in progress.
- slave_address  in  4  word offset: 0=start/result, 2=weight base address, 3=input base address, 5=length; others are don't-care.
- slave_read  in  1  slave read strobe.
- slave_readdata  out  32  slave read data.
- slave_write  in  1  slave write strobe.
- slave_writedata  in  32  slave write data.
- master_waitrequest  in  1  memory not ready to accept the request.
- master_address  out  32  byte address of the word to fetch.
- master_read  out  1  master read request.
- master_readdata  in  32  fetched word.
- master_readdatavalid  in  1  master_readdata is valid this cycle.
- master_write  out  1  tied to 0.
- master_writedata  out  32  tied to 0.

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE; weight address, input address, length, index and result registers = 0; master_read=0; master_address=0; slave_waitrequest=0.
- Slave writes in IDLE are accepted in one cycle:
  - Offset 2 loads the weight base address.
  - Offset 3 loads the input base address.
  - Offset 5 loads the length, as an unsigned element count.
  - Offset 0 with any data clears the accumulator and index and starts a computation.
  - Other offsets are ignored.
- slave_readdata is combinational. Offset 0 returns the result register; offsets 2, 3 and 5 return their registers; all other offsets return 0.
- slave_waitrequest = (state != IDLE) & (slave_read | slave_write). Any access during a computation is held until it completes, then serviced in IDLE.
- States: IDLE -> RD_W -> WT_W -> RD_I -> WT_I -> ACC -> (RD_W, or IDLE when index == length).
- Start with length 0 goes straight back to IDLE; the result is 0.
- RD_W:
  - master_address = weight base + 4*index; master_read=1.
  - Held stable until a cycle with master_waitrequest=0, then go to WT_W with master_read=0.
- WT_W: wait for master_readdatavalid, capture the weight, go to RD_I.
- RD_I / WT_I: same handshake using input base + 4*index; capture the input.
- ACC:
  - Form the signed 32x32 product as 64 bits.
  - Arithmetic right shift by 16 and take the low 32 bits.
  - Add to the accumulator with 32-bit two's-complement wrap (no saturation).
  - Increment index.
- Exactly one outstanding master read at a time; no pipelining.
- readdatavalid arriving outside WT_W/WT_I is ignored.
- The result register holds its value until the next start or reset.
- Base addresses are byte addresses and are used unaligned as given.
- Reset mid-computation aborts immediately: master_read drops, state goes to IDLE, all registers clear.
- Slave writes to offsets 2, 3 and 5 during a computation are stalled, never lost.

Test Plan:
1. Program weights base 0x1000, inputs base 0x2000, length 8; memory holds weights 100,200,…,800 and inputs 50,100,…,400; write offset 0 -> master fetches 0x1000, 0x2000, 0x1004, 0x2004, …, 0x101C, 0x201C in that order; read offset 0 returns 11.
2. Length 1, weight 0x00018000 (1.5), input 0x00020000 (2.0) -> result 0x00030000.
3. Length 2, weights 0xFFFF0000 (-1.0) and 0x00010000, inputs 0x00008000 (0.5) and 0x00010000 -> result 0x00008000.
4. Length 0, start -> no master reads issued; result 0; a read of offset 0 gets slave_waitrequest=0 within 2 cycles.
5. Memory holds master_waitrequest=1 for 3 cycles per request and returns readdatavalid 2 cycles later; rerun scenario 1 -> master_address/master_read stay stable while stalled; result is still 11. A slave read of offset 0 issued right after start sees slave_waitrequest=1 until done.
6. Assert rst_n=0 for one cycle mid-scenario 1 -> master_read=0 and result 0 on the next cycle; a fresh program-and-start yields 11.

Source files
------------

// File: rtl/dot_product.sv
// Memory-mapped Q16.16 dot-product accelerator.
// The CPU programs base addresses and length over the slave port, then starts.
// Both vectors are fetched one word at a time over the master port, and the
// Q16.16 products are accumulated into the result register.
module dot_product (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  typedef enum logic [2:0] {IDLE, RD_W, WT_W, RD_I, WT_I, ACC} state_t;

  state_t      state, state_nxt;
  logic [31:0] w_base, i_base, len, idx, acc;
  logic [31:0] w_val, i_val;
  logic [31:0] idx_inc;
  logic        wr_ok, start;

  // Bits [47:16] of the full 64-bit product equal the low word of the product
  // shifted right by 16, so a 48-bit sign-extended multiply is sufficient.
  logic signed [47:0] w_ext, i_ext, prod;
  logic               unused_prod_lo;

  assign w_ext          = {{16{w_val[31]}}, w_val};
  assign i_ext          = {{16{i_val[31]}}, i_val};
  assign prod           = w_ext * i_ext;
  assign unused_prod_lo = ^prod[15:0];

  assign idx_inc = idx + 32'd1;
  assign wr_ok   = slave_write && (state == IDLE);
  assign start   = wr_ok && (slave_address == 4'd0);

  assign slave_waitrequest = (state != IDLE) && (slave_read || slave_write);
  assign master_write      = 1'b0;
  assign master_writedata  = '0;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and master request outputs.
  always_comb begin
    state_nxt      = state;
    master_read    = 1'b0;
    master_address = '0;
    case (state)
      IDLE: if (start && (len != '0)) state_nxt = RD_W;
      RD_W: begin
        master_read    = 1'b1;
        master_address = w_base + (idx << 2);
        if (!master_waitrequest) state_nxt = WT_W;
      end
      WT_W: if (master_readdatavalid) state_nxt = RD_I;
      RD_I: begin
        master_read    = 1'b1;
        master_address = i_base + (idx << 2);
        if (!master_waitrequest) state_nxt = WT_I;
      end
      WT_I: if (master_readdatavalid) state_nxt = ACC;
      ACC:  state_nxt = (idx_inc == len) ? IDLE : RD_W;
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration registers, operand capture and accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_base <= '0;
      i_base <= '0;
      len    <= '0;
      idx    <= '0;
      acc    <= '0;
      w_val  <= '0;
      i_val  <= '0;
    end else begin
      if (wr_ok) begin
        case (slave_address)
          4'd0: begin
            acc <= '0;
            idx <= '0;
          end
          4'd2: w_base <= slave_writedata;
          4'd3: i_base <= slave_writedata;
          4'd5: len    <= slave_writedata;
          default: ;
        endcase
      end
      if (state == WT_W && master_readdatavalid) w_val <= master_readdata;
      if (state == WT_I && master_readdatavalid) i_val <= master_readdata;
      if (state == ACC) begin
        acc <= acc + prod[47:16];
        idx <= idx_inc;
      end
    end
  end

  // Slave read mux.
  always_comb begin
    slave_readdata = '0;
    case (slave_address)
      4'd0:    slave_readdata = acc;
      4'd2:    slave_readdata = w_base;
      4'd3:    slave_readdata = i_base;
      4'd5:    slave_readdata = len;
      default: slave_readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dot_product.sv
// Randomized self-checking bench for dot_product with a memory model that
// injects request stalls, response latency and stray readdatavalid pulses.
module tb_dot_product;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = '0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata = '0;
  logic        master_readdatavalid = 1'b0;
  logic        master_write;
  logic [31:0] master_writedata;

  always #5 clk = ~clk;

  dot_product dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Memory model
  logic [31:0] mem [logic [31:0]];
  logic [31:0] fetch_q[$];
  int          stall_cfg = 0;
  int          lat_cfg = 0;
  int          stall_cnt = 0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic        prev_stalled = 1'b0;
  logic [31:0] prev_addr = '0;

  assign master_waitrequest = master_read && (stall_cnt < stall_cfg);

  // Accept requests after the configured stall, answer after the latency,
  // and emit stray valid pulses whenever no response is owed.
  always @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt            <= 0;
      pend                 <= 1'b0;
      master_readdatavalid <= 1'b0;
      prev_stalled         <= 1'b0;
    end else begin
      if (prev_stalled) begin
        check("stall_read_held", {31'd0, master_read}, 32'd1);
        check("stall_addr_held", master_address, prev_addr);
      end
      prev_stalled         <= master_read && master_waitrequest;
      prev_addr            <= master_address;
      master_readdatavalid <= 1'b0;
      master_readdata      <= $urandom;
      if (master_read && master_waitrequest) begin
        stall_cnt <= stall_cnt + 1;
      end else if (master_read) begin
        stall_cnt <= 0;
        fetch_q.push_back(master_address);
        pend      <= 1'b1;
        pend_cnt  <= lat_cfg;
        pend_addr <= master_address;
      end
      if (pend) begin
        if (pend_cnt == 0) begin
          master_readdatavalid <= 1'b1;
          master_readdata      <= mem.exists(pend_addr) ? mem[pend_addr] : 32'hDEAD_BEEF;
          pend                 <= 1'b0;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end else if (!(master_read && !master_waitrequest)) begin
        master_readdatavalid <= ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Reference: each Q16.16 term is the exact product shifted right by 16.
  function automatic logic [31:0] ref_term(input logic [31:0] w, input logic [31:0] x);
    longint p, s;
    p = longint'(int'(w)) * longint'(int'(x));
    s = p >>> 16;
    return s[31:0];
  endfunction

  task automatic slave_wr(input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(negedge clk);
    while (slave_waitrequest && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) check("wr_timeout", 32'd0, 32'd1);
    @(posedge clk); #1 slave_write = 1'b0;
  endtask

  task automatic slave_rd(input logic [3:0] a, output logic [31:0] d, output int waits);
    waits = 0;
    slave_address = a; slave_read = 1'b1;
    @(negedge clk);
    while (slave_waitrequest && waits < 5000) begin @(negedge clk); waits++; end
    if (waits >= 5000) check("rd_timeout", 32'd0, 32'd1);
    d = slave_readdata;
    @(posedge clk); #1 slave_read = 1'b0;
  endtask

  task automatic run_job(input string tag, input logic [31:0] wb, input logic [31:0] ib,
                         input logic [31:0] wv[$], input logic [31:0] iv[$],
                         input int st, input int lt, input bit mid_wr);
    int          n = wv.size();
    int          waits;
    logic [31:0] exp_res = '0;
    logic [31:0] r;
    logic [31:0] exp_wb = wb;
    logic [31:0] exp_addr[$];
    mem.delete(); fetch_q.delete();
    stall_cfg = st; lat_cfg = lt;
    for (int k = 0; k < n; k++) begin
      mem[wb + 32'(4 * k)] = wv[k];
      mem[ib + 32'(4 * k)] = iv[k];
      exp_res += ref_term(wv[k], iv[k]);
      exp_addr.push_back(wb + 32'(4 * k));
      exp_addr.push_back(ib + 32'(4 * k));
    end
    slave_wr(4'd2, wb); slave_wr(4'd3, ib); slave_wr(4'd5, 32'(n));
    slave_wr(4'd0, $urandom);
    if (mid_wr) begin
      exp_wb = wb ^ 32'h5A5A_0000;
      slave_wr(4'd2, exp_wb);
    end
    slave_rd(4'd0, r, waits);
    check({tag, "_result"}, r, exp_res);
    if (n == 0) check({tag, "_len0_quick"}, {31'd0, (waits <= 2)}, 32'd1);
    else if (!mid_wr) check({tag, "_rd_stalled"}, {31'd0, (waits > 0)}, 32'd1);
    check({tag, "_fetch_cnt"}, 32'(fetch_q.size()), 32'(exp_addr.size()));
    for (int k = 0; k < exp_addr.size() && k < fetch_q.size(); k++)
      check($sformatf("%s_addr%0d", tag, k), fetch_q[k], exp_addr[k]);
    slave_rd(4'd2, r, waits); check({tag, "_wbase"}, r, exp_wb);
    slave_rd(4'd3, r, waits); check({tag, "_ibase"}, r, ib);
    slave_rd(4'd5, r, waits); check({tag, "_len"}, r, 32'(n));
  endtask

  logic [31:0] s1w[$], s1i[$], wv[$], iv[$];
  logic [31:0] r;
  int          waits;

  initial begin
    for (int k = 1; k <= 8; k++) begin
      s1w.push_back(32'(100 * k));
      s1i.push_back(32'(50 * k));
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_waitreq", {31'd0, slave_waitrequest}, 32'd0);
    check("rst_mread", {31'd0, master_read}, 32'd0);
    check("rst_maddr", master_address, 32'd0);
    check("rst_mwrite", {31'd0, master_write}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    slave_rd(4'd0, r, waits); check("rst_result", r, 32'd0);
    slave_rd(4'd2, r, waits); check("rst_wbase", r, 32'd0);
    slave_rd(4'd3, r, waits); check("rst_ibase", r, 32'd0);
    slave_rd(4'd5, r, waits); check("rst_len", r, 32'd0);

    // Directed scenarios
    run_job("s1", 32'h1000, 32'h2000, s1w, s1i, 0, 0, 1'b0);
    slave_rd(4'd0, r, waits); check("s1_const", r, 32'd11);
    slave_rd(4'd4, r, waits); check("unmapped_rd", r, 32'd0);
    run_job("s2", 32'h3000, 32'h4000, '{32'h0001_8000}, '{32'h0002_0000}, 0, 0, 1'b0);
    slave_rd(4'd0, r, waits); check("s2_const", r, 32'h0003_0000);
    run_job("s3", 32'h3000, 32'h4000, '{32'hFFFF_0000, 32'h0001_0000},
            '{32'h0000_8000, 32'h0001_0000}, 0, 0, 1'b0);
    slave_rd(4'd0, r, waits); check("s3_const", r, 32'h0000_8000);
    run_job("s4", 32'h5000, 32'h6000, wv, iv, 0, 0, 1'b0);
    run_job("s5", 32'h1000, 32'h2000, s1w, s1i, 3, 2, 1'b0);
    run_job("s5w", 32'h1000, 32'h2000, s1w, s1i, 3, 2, 1'b1);

    // Reset mid-computation
    stall_cfg = 3; lat_cfg = 2;
    slave_wr(4'd2, 32'h1000); slave_wr(4'd3, 32'h2000); slave_wr(4'd5, 32'd8);
    slave_wr(4'd0, 32'd0);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    slave_address = 4'd0;
    @(negedge clk);
    check("s6_mread", {31'd0, master_read}, 32'd0);
    check("s6_result", slave_readdata, 32'd0);
    check("s6_waitreq", {31'd0, slave_waitrequest}, 32'd0);
    slave_address = 4'd5;
    #1 check("s6_len", slave_readdata, 32'd0);
    rst_n = 1'b1;
    run_job("s6", 32'h1000, 32'h2000, s1w, s1i, 0, 1, 1'b0);

    // Random jobs
    for (int j = 0; j < 20; j++) begin
      int n = $urandom_range(0, 6);
      wv.delete(); iv.delete();
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 1) == 0) begin
          wv.push_back($urandom); iv.push_back($urandom);
        end else begin
          wv.push_back(32'($signed($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000));
          iv.push_back(32'($signed($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000));
        end
      end
      run_job($sformatf("rnd%0d", j), 32'h0001_0000 + 32'($urandom_range(0, 255)),
              32'h0002_0000 + 32'($urandom_range(0, 255)), wv, iv,
              $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    check("global_timeout", 32'd0, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "FAIL global_timeout");
  end

endmodule
